// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the fetch-address controller.
package pc_fetch_ctrl_pkg;

  localparam logic [1:0] PC_ROM_OP_NOP   = 2'b00;
  localparam logic [1:0] PC_ROM_OP_READ  = 2'b01;
  localparam logic [1:0] PC_ROM_OP_WRITE = 2'b10;

  localparam logic ROM_OP_READ  = 1'b0;
  localparam logic ROM_OP_WRITE = 1'b1;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selector: flush > branch > sequential, modulo 2^ADDR_W.
// Optional low-bit alignment of the chosen redirect under PC_MISALIGN_CHECK_EN.
module pc_next_sel
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int PC_STEP = 4
) (
  input  logic              flush,
  input  logic              branch,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [ADDR_W-1:0] m_pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misalign
);

  logic [ADDR_W-1:0] raw_pc;

  always_comb begin
    if (flush) begin
      raw_pc = new_pc;
    end else if (branch) begin
      raw_pc = branch_target;
    end else begin
      raw_pc = m_pc + ADDR_W'(PC_STEP);
    end
`ifdef PC_MISALIGN_CHECK_EN
    misalign = |raw_pc[1:0];
    next_pc  = {raw_pc[ADDR_W-1:2], 2'b00};
`else
    misalign = 1'b0;
    next_pc  = raw_pc;
`endif
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-address controller for the shared instruction/data ROM with ready handshake.
// Optional macro PC_MISALIGN_CHECK_EN aligns redirects and pulses misalign_o.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              PC_STEP   = 4,
  parameter int              STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  input  logic [1:0]         rom_op_i,
  input  logic [DATA_W-1:0]  rom_wr_data_i,
  input  logic [ADDR_W-1:0]  rom_rw_addr_i,
  input  logic               rom_ready_i,
  output logic [ADDR_W-1:0]  addr,
  output logic               ce,
  output logic               rom_op_o,
  output logic [DATA_W-1:0]  wr_data_o,
  output logic               fetch_valid_o,
  output logic               data_busy_o,
  output logic               misalign_o
);

  pc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, m_pc_q, m_pc_d;
  logic              ce_q, ce_d, op_q, op_d, busy_q, busy_d, mis_q, mis_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [ADDR_W-1:0] next_pc;
  logic              next_mis;
  logic              mem_req;
  logic              unused_stall;

  // Upper stall bits belong to later pipeline stages.
  assign unused_stall = ^{stall, 1'b0};
  assign mem_req = (rom_op_i == PC_ROM_OP_READ) || (rom_op_i == PC_ROM_OP_WRITE);

  pc_next_sel #(.ADDR_W(ADDR_W), .PC_STEP(PC_STEP)) u_next_sel (
    .flush         (flush),
    .branch        (branch_flag_i && (state_q == FETCH)),
    .new_pc        (new_pc),
    .branch_target (branch_target_address_i),
    .m_pc          (m_pc_q),
    .next_pc       (next_pc),
    .misalign      (next_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET;
      addr_q  <= RESET_VEC;
      m_pc_q  <= RESET_VEC;
      ce_q    <= ChipDisable;
      op_q    <= ROM_OP_READ;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      m_pc_q  <= m_pc_d;
      ce_q    <= ce_d;
      op_q    <= op_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    m_pc_d  = m_pc_q;
    ce_d    = ce_q;
    op_d    = op_q;
    wd_d    = wd_q;
    busy_d  = busy_q;
    mis_d   = 1'b0;
    case (state_q)
      RESET: begin
        state_d = FETCH;
        ce_d    = ChipEnable;
      end
      FETCH: begin
        if (flush || (!stall[0] && rom_ready_i && !mem_req)) begin
          addr_d = next_pc;
          m_pc_d = next_pc;
          mis_d  = next_mis;
        end else if (!stall[0] && rom_ready_i) begin
          // Data access borrows the port; m_pc keeps the fetch position.
          addr_d  = rom_rw_addr_i;
          op_d    = (rom_op_i == PC_ROM_OP_WRITE) ? ROM_OP_WRITE : ROM_OP_READ;
          wd_d    = rom_wr_data_i;
          busy_d  = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (flush || rom_ready_i) begin
          addr_d  = next_pc;
          m_pc_d  = next_pc;
          mis_d   = next_mis;
          op_d    = ROM_OP_READ;
          busy_d  = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = RESET;
    endcase
  end

  assign addr          = addr_q;
  assign ce            = ce_q;
  assign rom_op_o      = op_q;
  assign wr_data_o     = wd_q;
  assign data_busy_o   = busy_q;
  assign misalign_o    = mis_q;
  assign fetch_valid_o = (state_q == FETCH) && ce_q && rom_ready_i && !stall[0];

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_pc_fetch_ctrl;

  localparam int          AW = 32;
  localparam int          DW = 32;
  localparam int          SW = 6;
  localparam logic [31:0] RV = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst, flush, branch_flag_i, rom_ready_i;
  logic [AW-1:0] new_pc, branch_target_address_i, rom_rw_addr_i;
  logic [SW-1:0] stall;
  logic [1:0]    rom_op_i;
  logic [DW-1:0] rom_wr_data_i;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data_o;
  logic          ce, rom_op_o, fetch_valid_o, data_busy_o, misalign_o;

  int total = 0;
  int bad   = 0;

  pc_fetch_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RESET_VEC(RV), .PC_STEP(4), .STALL_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .new_pc(new_pc), .stall(stall),
    .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i),
    .rom_op_i(rom_op_i), .rom_wr_data_i(rom_wr_data_i), .rom_rw_addr_i(rom_rw_addr_i),
    .rom_ready_i(rom_ready_i), .addr(addr), .ce(ce), .rom_op_o(rom_op_o),
    .wr_data_o(wr_data_o), .fetch_valid_o(fetch_valid_o), .data_busy_o(data_busy_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; new_pc = '0; stall = '0; branch_flag_i = 0;
    branch_target_address_i = '0; rom_op_i = 2'b00; rom_wr_data_i = '0;
    rom_rw_addr_i = '0; rom_ready_i = 1;
    repeat (3) tick();
    total++;
    if (addr !== RV) begin bad++; $display("FAIL reset_addr got=%h want=%h", addr, RV); end
    total++;
    if ({ce, rom_op_o, data_busy_o, misalign_o, fetch_valid_o} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=00000",
                      {ce, rom_op_o, data_busy_o, misalign_o, fetch_valid_o});
    end
    total++;
    if (wr_data_o !== '0) begin bad++; $display("FAIL reset_wd got=%h want=0", wr_data_o); end
  endtask

  task automatic test_sequential();
    rst = 0;
    tick();
    total++;
    if ({ce, fetch_valid_o, addr} !== {2'b11, RV}) begin
      bad++; $display("FAIL seq_first got ce=%b fv=%b addr=%h want 1 1 %h", ce, fetch_valid_o, addr, RV);
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++;
      if ({fetch_valid_o, addr} !== {1'b1, RV + 32'(4 * i)}) begin
        bad++; $display("FAIL seq_step%0d got fv=%b addr=%h want 1 %h", i, fetch_valid_o, addr, RV + 32'(4 * i));
      end
    end
  endtask

  task automatic test_data_write();
    flush = 1; new_pc = 32'h10;
    tick();
    flush = 0;
    total++;
    if (addr !== 32'h10) begin bad++; $display("FAIL wr_setup got=%h want=10", addr); end
    rom_op_i = 2'b10; rom_rw_addr_i = 32'h200; rom_wr_data_i = 32'hDEAD_BEEF;
    tick();
    rom_op_i = 2'b00; rom_ready_i = 0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({addr, rom_op_o, data_busy_o, wr_data_o} !== {32'h200, 2'b11, 32'hDEAD_BEEF}) begin
        bad++; $display("FAIL wr_busy%0d got addr=%h op=%b busy=%b wd=%h want 200 1 1 deadbeef",
                        c, addr, rom_op_o, data_busy_o, wr_data_o);
      end
      if (c < 2) tick();
    end
    total++;
    if (fetch_valid_o !== 1'b0) begin bad++; $display("FAIL wr_fv got=%b want=0", fetch_valid_o); end
    rom_ready_i = 1;
    tick();
    total++;
    if ({addr, rom_op_o, data_busy_o} !== {32'h14, 2'b00}) begin
      bad++; $display("FAIL wr_done got addr=%h op=%b busy=%b want 14 0 0", addr, rom_op_o, data_busy_o);
    end
  endtask

  task automatic test_priority();
    flush = 1; new_pc = 32'h1000; branch_flag_i = 1; branch_target_address_i = 32'h2000; stall = 6'h01;
    #1;
    total++;
    if (fetch_valid_o !== 1'b0) begin bad++; $display("FAIL prio_fv got=%b want=0", fetch_valid_o); end
    tick();
    total++;
    if (addr !== 32'h1000) begin bad++; $display("FAIL prio_flush got=%h want=1000", addr); end
    flush = 0;
    tick();
    total++;
    if (addr !== 32'h1000) begin bad++; $display("FAIL prio_stall got=%h want=1000", addr); end
    stall = '0;
    tick();
    branch_flag_i = 0;
    total++;
    if (addr !== 32'h2000) begin bad++; $display("FAIL prio_branch got=%h want=2000", addr); end
  endtask

  task automatic test_flush_data();
    rom_op_i = 2'b01; rom_rw_addr_i = 32'h300;
    tick();
    rom_op_i = 2'b00;
    total++;
    if ({addr, rom_op_o, data_busy_o} !== {32'h300, 2'b01}) begin
      bad++; $display("FAIL fd_enter got addr=%h op=%b busy=%b want 300 0 1", addr, rom_op_o, data_busy_o);
    end
    rom_ready_i = 0; flush = 1; new_pc = 32'h400;
    tick();
    flush = 0;
    total++;
    if ({addr, rom_op_o, data_busy_o} !== {32'h400, 2'b00}) begin
      bad++; $display("FAIL fd_abort got addr=%h op=%b busy=%b want 400 0 0", addr, rom_op_o, data_busy_o);
    end
    rom_ready_i = 1;
    #1;
    total++;
    if (fetch_valid_o !== 1'b1) begin bad++; $display("FAIL fd_fv got=%b want=1", fetch_valid_o); end
    tick();
    total++;
    if (addr !== 32'h404) begin bad++; $display("FAIL fd_resume got=%h want=404", addr); end
  endtask

  task automatic test_wrap();
    flush = 1; new_pc = 32'hFFFF_FFFC;
    tick();
    flush = 0;
    tick();
    total++;
    if (addr !== 32'h0) begin bad++; $display("FAIL wrap got=%h want=0", addr); end
  endtask

  task automatic test_misalign();
    logic [31:0] want_a, want_b;
    logic        want_m;
`ifdef PC_MISALIGN_CHECK_EN
    want_a = 32'h100; want_m = 1; want_b = 32'h104;
`else
    want_a = 32'h103; want_m = 0; want_b = 32'h107;
`endif
    branch_flag_i = 1; branch_target_address_i = 32'h103;
    tick();
    branch_flag_i = 0;
    total++;
    if ({addr, misalign_o} !== {want_a, want_m}) begin
      bad++; $display("FAIL mis_br got addr=%h mis=%b want %h %b", addr, misalign_o, want_a, want_m);
    end
    tick();
    total++;
    if ({addr, misalign_o} !== {want_b, 1'b0}) begin
      bad++; $display("FAIL mis_next got addr=%h mis=%b want %h 0", addr, misalign_o, want_b);
    end
  endtask

  // Transaction-level reference: port busy with fetch or a data access.
  bit          m_live, m_data;
  logic [31:0] e_addr, e_pc, e_wd;
  logic        e_ce, e_op, e_busy, e_mis;

  task automatic m_go(input logic [31:0] a);
`ifdef PC_MISALIGN_CHECK_EN
    e_mis = (a[1:0] != 2'b00);
    a     = a & 32'hFFFF_FFFC;
`endif
    e_addr = a;
    e_pc   = a;
  endtask

  task automatic m_clock();
    e_mis = 0;
    if (rst) begin
      m_live = 0; m_data = 0; e_addr = RV; e_pc = RV; e_ce = 0; e_op = 0; e_wd = 0; e_busy = 0;
    end else if (!m_live) begin
      m_live = 1; e_ce = 1;
    end else if (m_data) begin
      if (flush) m_go(new_pc);
      else if (rom_ready_i) m_go(e_pc + 32'd4);
      if (flush || rom_ready_i) begin m_data = 0; e_op = 0; e_busy = 0; end
    end else if (flush) begin
      m_go(new_pc);
    end else if (!stall[0] && rom_ready_i) begin
      if (rom_op_i == 2'b01 || rom_op_i == 2'b10) begin
        m_data = 1; e_addr = rom_rw_addr_i; e_op = (rom_op_i == 2'b10);
        e_wd = rom_wr_data_i; e_busy = 1;
      end else if (branch_flag_i) begin
        m_go(branch_target_address_i);
      end else begin
        m_go(e_pc + 32'd4);
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic test_random();
    logic exp_fv;
    rst = 1;
    m_clock();
    tick();
    for (int n = 0; n < 600; n++) begin
      rst           = (n == 0) || ($urandom_range(0, 63) == 0);
      flush         = ($urandom_range(0, 15) == 0);
      new_pc        = rand_addr();
      stall         = SW'($urandom) & {{(SW-1){1'b1}}, ($urandom_range(0, 3) == 0)};
      branch_flag_i = ($urandom_range(0, 3) == 0);
      branch_target_address_i = rand_addr();
      rom_op_i      = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      rom_rw_addr_i = $urandom;
      rom_wr_data_i = $urandom;
      rom_ready_i   = ($urandom_range(0, 3) != 0);
      #1;
      exp_fv = m_live && !m_data && e_ce && rom_ready_i && !stall[0];
      total++;
      if (fetch_valid_o !== exp_fv) begin
        bad++; $display("FAIL rnd_fv cyc=%0d got=%b want=%b", n, fetch_valid_o, exp_fv);
      end
      tick();
      m_clock();
      total++;
      if ({addr, ce, rom_op_o, data_busy_o, misalign_o, wr_data_o} !==
          {e_addr, e_ce, e_op, e_busy, e_mis, e_wd}) begin
        bad++;
        $display("FAIL rnd_state cyc=%0d got addr=%h ce=%b op=%b busy=%b mis=%b wd=%h want %h %b %b %b %b %h",
                 n, addr, ce, rom_op_o, data_busy_o, misalign_o, wr_data_o,
                 e_addr, e_ce, e_op, e_busy, e_mis, e_wd);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_sequential();
    test_data_write();
    test_priority();
    test_flush_data();
    test_wrap();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
